display_arbiter: RTL and testbench

Shares the single 3-digit seven-segment display driver between NUM_REQ independent result producers (ALU, status/error sources, etc.). It grants the display round-robin, latches the winner's 6-bit signed result and 3-bit opcode, and holds it for a minimum dwell time so each value is readable. It sits between the requesters and the display scan/decode block, and drives that block's result and opcodesel inputs.

---
 rtl/disp_arb_pkg.sv | 14 +
 rtl/display_arbiter_rr_picker.sv | 31 +++
 rtl/display_arbiter.sv | 139 +++++++++++++
 tb/tb_display_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display arbiter: FSM state encoding and
// the widths of the result/opcode fields handed to the seven-segment driver.
package disp_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } arb_state_e;

    localparam int RES_W = 6;
    localparam int OPC_W = 3;
    localparam logic [OPC_W-1:0] OPC_BINARY = 3'b110;

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// searching upward and wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic               any_req_o,
    output logic [PTR_W-1:0]   winner_o,
    output logic [NUM_REQ-1:0] winner_oh_o
);

    // Walk the rotated order from lowest priority to highest so the last hit wins.
    always_comb begin
        any_req_o   = |req_i;
        winner_o    = '0;
        winner_oh_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            winner_o = req_i[(int'(rr_ptr_i) + k) % NUM_REQ]
                     ? PTR_W'((int'(rr_ptr_i) + k) % NUM_REQ)
                     : winner_o;
        end
        if (any_req_o) begin
            winner_oh_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_o;
        end else begin
            winner_oh_o = '0;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between NUM_REQ producers,
// holding each granted value for DWELL_CYCLES. Define DISP_ARB_PREEMPT_EN to let requester 0 preempt.
module display_arbiter
    import disp_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic                     clk_in,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [RES_W*NUM_REQ-1:0] req_result,
    input  logic [OPC_W*NUM_REQ-1:0] req_opcode,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       grant,
    output logic [RES_W-1:0]         disp_result,
    output logic [OPC_W-1:0]         disp_opcodesel,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);
`ifdef DISP_ARB_PREEMPT_EN
    localparam logic [NUM_REQ-1:0] URGENT_OH = {{(NUM_REQ-1){1'b0}}, 1'b1};
`endif

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [OPC_W-1:0]   opc_q, opc_d;

    logic               any_req_s;
    logic [PTR_W-1:0]   winner_s;
    logic [NUM_REQ-1:0] winner_oh_s;
    logic [PTR_W-1:0]   rr_next_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .any_req_o   (any_req_s),
        .winner_o    (winner_s),
        .winner_oh_o (winner_oh_s)
    );

    assign rr_next_s = (int'(winner_s) == NUM_REQ - 1) ? '0 : winner_s + 1'b1;

    // Next-state: arbitrate from IDLE or at the end of a dwell, otherwise count the dwell down.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        ack_d    = '0;
        grant_d  = grant_q;
        res_d    = res_q;
        opc_d    = opc_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (any_req_s) begin
                    state_d  = ST_SHOW;
                    rr_ptr_d = rr_next_s;
                    count_d  = DWELL_RELOAD;
                    ack_d    = winner_oh_s;
                    grant_d  = winner_oh_s;
                    res_d    = req_result[int'(winner_s)*RES_W +: RES_W];
                    opc_d    = req_opcode[int'(winner_s)*OPC_W +: OPC_W];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHOW: begin
`ifdef DISP_ARB_PREEMPT_EN
                // Urgent requester aborts the current dwell; rotation pointer is left alone.
                if (req[0] && !grant_q[0]) begin
                    count_d = DWELL_RELOAD;
                    ack_d   = URGENT_OH;
                    grant_d = URGENT_OH;
                    res_d   = req_result[RES_W-1:0];
                    opc_d   = req_opcode[OPC_W-1:0];
                end else
`endif
                if (count_q == '0) begin
                    if (any_req_s) begin
                        rr_ptr_d = rr_next_s;
                        count_d  = DWELL_RELOAD;
                        ack_d    = winner_oh_s;
                        grant_d  = winner_oh_s;
                        res_d    = req_result[int'(winner_s)*RES_W +: RES_W];
                        opc_d    = req_opcode[int'(winner_s)*OPC_W +: OPC_W];
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= '0;
            grant_q  <= '0;
            res_q    <= '0;
            opc_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            grant_q  <= grant_d;
            res_q    <= res_d;
            opc_q    <= opc_d;
        end
    end

    assign ack            = ack_q;
    assign grant          = grant_q;
    assign disp_result    = res_q;
    assign disp_opcodesel = opc_q;
    assign busy           = (state_q == ST_SHOW);

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter (NUM_REQ=4, DWELL_CYCLES=4): directed
// vector table, hand-written corner sequences, then random traffic against a reference model.
module tb_display_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [23:0] req_result;
    logic [11:0] req_opcode;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [5:0]  disp_result;
    logic [2:0]  disp_opcodesel;
    logic        busy;

    int errors = 0;
    int checks = 0;

    display_arbiter #(
        .NUM_REQ      (N),
        .DWELL_CYCLES (D),
        .CNT_W        (3)
    ) dut (
        .clk_in         (clk_in),
        .reset_n        (rst_n),
        .req            (req),
        .req_result     (req_result),
        .req_opcode     (req_opcode),
        .ack            (ack),
        .grant          (grant),
        .disp_result    (disp_result),
        .disp_opcodesel (disp_opcodesel),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] ack;
        logic [3:0] grant;
        logic [5:0] res;
        logic [2:0] opc;
        logic       busy;
    } vec_t;

    vec_t tbl[13];

    // reference model state
    int         m_owner;
    int         m_left;
    int         m_rr;
    logic [5:0] m_res;
    logic [2:0] m_opc;
    logic [3:0] m_ack;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] got;
        got = {ack, grant, disp_result, disp_opcodesel, busy};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ack=%b grant=%b res=%h opc=%b busy=%b, expected ack=%b grant=%b res=%h opc=%b busy=%b",
                     name, got[17:14], got[13:10], got[9:4], got[3:1], got[0],
                     exp[17:14], exp[13:10], exp[9:4], exp[3:1], exp[0]);
        end
    endtask

    task automatic model_serve(input int w);
        m_owner = w;
        m_left  = D - 1;
        m_res   = req_result[6*w +: 6];
        m_opc   = req_opcode[3*w +: 3];
        m_ack   = 4'b0001 << w;
    endtask

    // Model of one clock edge using the currently driven inputs.
    task automatic model_edge();
        int  w;
        int  idx;
        bit  pre;
        if (!rst_n) begin
            m_owner = -1; m_left = 0; m_rr = 0;
            m_res = 6'h00; m_opc = 3'b000; m_ack = 4'b0000;
        end else begin
            m_ack = 4'b0000;
            pre = 1'b0;
`ifdef DISP_ARB_PREEMPT_EN
            if (m_owner > 0 && req[0]) begin
                model_serve(0);
                pre = 1'b1;
            end
`endif
            if (!pre) begin
                if (m_owner < 0 || m_left == 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_rr + k) % N;
                        if (w < 0 && req[idx]) w = idx;
                    end
                    if (w >= 0) begin
                        model_serve(w);
                        m_rr = (w + 1) % N;
                    end else begin
                        m_owner = -1;
                    end
                end else begin
                    m_left = m_left - 1;
                end
            end
        end
    endtask

    function automatic logic [17:0] model_out();
        logic [3:0] g;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        return {m_ack, g, m_res, m_opc, (m_owner >= 0)};
    endfunction

    initial begin
        logic [3:0] eg;
        rst_n      = 1'b0;
        req        = 4'b0000;
        req_result = {6'h11, 6'h3B, 6'h2A, 6'h05};
        req_opcode = {3'b011, 3'b000, 3'b110, 3'b001};

        // reset with all requests up, release, then single request from requester 2
        tbl[0]  = '{1'b0, 4'hF, 4'h0, 4'h0, 6'h00, 3'b000, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 4'h0, 4'h0, 6'h00, 3'b000, 1'b0};
        tbl[2]  = '{1'b1, 4'hF, 4'h1, 4'h1, 6'h05, 3'b001, 1'b1};
        tbl[3]  = '{1'b1, 4'h0, 4'h0, 4'h1, 6'h05, 3'b001, 1'b1};
        tbl[4]  = '{1'b1, 4'h0, 4'h0, 4'h1, 6'h05, 3'b001, 1'b1};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 4'h1, 6'h05, 3'b001, 1'b1};
        tbl[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 6'h05, 3'b001, 1'b0};
        tbl[7]  = '{1'b1, 4'h4, 4'h4, 4'h4, 6'h3B, 3'b000, 1'b1};
        tbl[8]  = '{1'b1, 4'h0, 4'h0, 4'h4, 6'h3B, 3'b000, 1'b1};
        tbl[9]  = '{1'b1, 4'h0, 4'h0, 4'h4, 6'h3B, 3'b000, 1'b1};
        tbl[10] = '{1'b1, 4'h0, 4'h0, 4'h4, 6'h3B, 3'b000, 1'b1};
        tbl[11] = '{1'b1, 4'h0, 4'h0, 4'h0, 6'h3B, 3'b000, 1'b0};
        tbl[12] = '{1'b1, 4'h0, 4'h0, 4'h0, 6'h3B, 3'b000, 1'b0};

        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            step();
            check($sformatf("vec%0d", i),
                  {tbl[i].ack, tbl[i].grant, tbl[i].res, tbl[i].opc, tbl[i].busy});
        end

`ifndef DISP_ARB_PREEMPT_EN
        // all requesters held high: grants 0,1,2,3,0 back to back, 4 cycles each
        rst_n = 1'b0; req = 4'h0; step();
        rst_n = 1'b1; req = 4'hF;
        for (int k = 0; k < 20; k++) begin
            step();
            eg = 4'b0001 << ((k / D) % N);
            checks++;
            if (grant !== eg || ack !== ((k % D == 0) ? eg : 4'h0) || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_cycle%0d: got grant=%b ack=%b busy=%b expected grant=%b", k, grant, ack, busy, eg);
            end
        end
        // reset two cycles into requester 1's dwell, then pointer must be back at 0
        step(); step();
        check("rr_mid_dwell", {4'h0, 4'h2, 6'h2A, 3'b110, 1'b1});
        rst_n = 1'b0; step();
        check("reset_mid_dwell", {4'h0, 4'h0, 6'h00, 3'b000, 1'b0});
        rst_n = 1'b1; step();
        check("post_reset_ptr", {4'h1, 4'h1, 6'h05, 3'b001, 1'b1});
`else
        // requester 3 preempted by requester 0, then rotation resumes at requester 1
        rst_n = 1'b0; req = 4'h0; step();
        rst_n = 1'b1; req = 4'h8; step();
        check("pre_grant3", {4'h8, 4'h8, 6'h11, 3'b011, 1'b1});
        req = 4'h0; step();
        req = 4'h1; step();
        check("preempt0", {4'h1, 4'h1, 6'h05, 3'b001, 1'b1});
        req = 4'hA; step(); step(); step();
        check("preempt_hold", {4'h0, 4'h1, 6'h05, 3'b001, 1'b1});
        step();
        check("after_preempt", {4'h2, 4'h2, 6'h2A, 3'b110, 1'b1});
`endif

        // late request waits for the end of requester 3's dwell; data sampled only on ack
        rst_n = 1'b0; req = 4'h0; step();
        rst_n = 1'b1; req = 4'h8; step();
        check("late_grant3", {4'h8, 4'h8, 6'h11, 3'b011, 1'b1});
        req = 4'h0; step();
        req = 4'h2; step();
        check("late_wait", {4'h0, 4'h8, 6'h11, 3'b011, 1'b1});
        step();
        check("late_wait2", {4'h0, 4'h8, 6'h11, 3'b011, 1'b1});
        step();
        check("late_grant1", {4'h2, 4'h2, 6'h2A, 3'b110, 1'b1});
        req = 4'h0;
        req_result[11:6] = 6'h00;
        req_opcode[5:3]  = 3'b000;
        step();
        check("data_hold", {4'h0, 4'h2, 6'h2A, 3'b110, 1'b1});

        // random traffic against the reference model
        rst_n = 1'b0; req = 4'h0;
        model_edge(); step();
        check("rand_reset", model_out());
        for (int c = 0; c < 600; c++) begin
            rst_n      = ($urandom_range(0, 79) != 0);
            req        = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            req_result = 24'($urandom);
            req_opcode = 12'($urandom);
            model_edge();
            step();
            check($sformatf("rand%0d", c), model_out());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
